hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
// - Multi-cycle multiply/divide unit with architectural HI/LO registers, generalising the combinational 64-bit ALU path.
// - Handles MULT, MULTU, MADD, MSUB, MTHI and MTLO, plus DIV and DIVU when the divide option is compiled in.
// - Sits beside the EX-stage ALU. Busy stalls the pipeline; HI/LO feed MFHI/MFLO directly.
// PARAMETERS
// - WIDTH   32   operand width; HI and LO are each WIDTH bits, the product is 2*WIDTH
// PORTS
// - Clk      in   1        clock, rising edge
// - Rst_n    in   1        asynchronous active-low reset
// - Start    in   1        launch the operation on Op; sampled only when Busy=0
// - Op       in   3        0 MULT, 1 MULTU, 2 MADD, 3 MSUB, 4 DIV, 5 DIVU, 6 MTHI, 7 MTLO
// - A        in   WIDTH    rs operand (dividend / multiplicand / MTHI-MTLO source)
// - B        in   WIDTH    rt operand (divisor / multiplier)
// - Flush    in   1        abort the in-flight op; HI/LO stay unchanged
// - Busy     out  1        op in progress; the pipeline must stall
// - Done     out  1        one-cycle pulse when HI/LO have been committed
// - DivZero  out  1        one-cycle pulse with Done when DIV/DIVU had B==0
// - Illegal  out  1        one-cycle pulse with Done when the op is not supported
// - HI       out  WIDTH    HI register
// - LO       out  WIDTH    LO register
// BEHAVIOUR
// - Reset (async, Rst_n=0): HI=0, LO=0, Busy=0, Done=0, DivZero=0, Illegal=0, FSM=IDLE, counter=0.
// - FSM states: IDLE -> RUN -> FINISH -> IDLE.
// - IDLE, Start=1, Op in 0..5:
//   - Latch operand magnitudes, the result sign and the op; load counter=WIDTH-1.
//   - Go to RUN; Busy=1 from the next cycle.
// - IDLE, Start=1, Op=6 or 7: write HI=A or LO=A at that edge; Done pulses next cycle; Busy stays 0.
// - RUN: one radix-2 step per cycle.
//   - Multiply: shift-add on unsigned magnitudes.
//   - Divide: restoring, unsigned magnitudes.
//   - When counter==0, go to FINISH.
// - FINISH (1 cycle):
//   - Apply sign correction (two's complement negate).
//   - MADD/MSUB: add/subtract the product to/from {HI,LO}, modulo 2^(2*WIDTH).
//   - Commit HI/LO; Busy falls and Done pulses at the same edge.
// - Latency for ops 0..5: Start edge to Done high = WIDTH+1 cycles (33 at default); Busy high for WIDTH+1 cycles.
// - Signed rules:
//   - MULT/MADD/MSUB treat A and B as signed; MULTU treats them as unsigned.
//   - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
//   - Result: LO=quotient, HI=remainder.
// - Divide by zero: HI=A, LO={WIDTH{1'b1}}, DivZero=1 with Done; latency unchanged.
// - Most-negative case: DIV of -2^(W-1) by -1 gives LO=-2^(W-1), HI=0 (wraps); no flag.
// - Start while Busy=1: ignored; no queueing.
// - Flush: returns the FSM to IDLE at the next edge, Busy=0, no Done, HI/LO untouched.
//   - Flush together with Start in IDLE: Flush wins and the op is not launched.
//   - Flush in FINISH: the commit is suppressed.
// - Reset mid-operation: aborts immediately; HI/LO go to 0.
// - HI/LO hold their values whenever no commit occurs; MFHI/MFLO read the ports combinationally.
// CONFIGURATION
// - HILO_MULDIV_DIV_EN defined: DIV/DIVU are implemented as above.
// - HILO_MULDIV_DIV_EN undefined: the divide datapath is removed.
//   - Op 4/5 with Start: no RUN; Done and Illegal pulse next cycle.
//   - HI/LO unchanged; Busy stays 0.
// TESTING
// - MULT A=-3 (0xFFFFFFFD), B=7 -> Done at cycle 33: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
// - MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
// - MTHI A=5, then MADD A=2, B=3 with LO=0xFFFFFFFF -> HI=0x6, LO=0x5 (carry into HI).
// - DIV A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU A=9, B=0 -> DivZero=1, HI=9, LO=0xFFFFFFFF.
// - Start MULT, Flush at cycle 10 -> Busy=0 at cycle 11, no Done, HI/LO unchanged; a second Start during Busy is ignored.
// - Rst_n low at cycle 5 of MSUB -> all outputs 0 asynchronously; the next MULT 2*3 gives LO=6.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Purpose : multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Latency : ops 0..5 take WIDTH+1 cycles from the Start edge to Done; MTHI/MTLO/illegal ops finish at the Start edge.
// Backpr. : busy_o stalls the pipeline; start_i is ignored while busy; flush_i aborts without touching HI/LO.
//
// Ports: clk_i/rst_n_i (async active-low), start_i + op_i + a_i/b_i launch an op,
//        flush_i aborts, busy_o/done_o/div_zero_o/illegal_o status, hi_o/lo_o architectural registers.
// Build option: define HILO_MULDIV_DIV_EN to include the DIV/DIVU datapath; otherwise
//        ops 4/5 complete immediately with illegal_o and leave HI/LO unchanged.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic             illegal_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;
    typedef enum logic [2:0] {
        OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_MADD = 3'd2, OP_MSUB = 3'd3,
        OP_DIV  = 3'd4, OP_DIVU  = 3'd5, OP_MTHI = 3'd6, OP_MTLO = 3'd7
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d, op_in;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;          // sign of product / quotient
    logic [WIDTH-1:0]   mag_q, mag_d;          // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0] p_q, p_d;              // shift register: {acc/rem, multiplier/quotient}
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, divz_q, divz_d, illegal_q, illegal_d;

    assign op_in = op_e'(op_i);

    // Operand magnitudes; the sign is folded back in FINISH.
    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign signed_op = (op_in == OP_MULT) || (op_in == OP_MADD) ||
                       (op_in == OP_MSUB) || (op_in == OP_DIV);
    assign a_neg = signed_op && a_i[WIDTH-1];
    assign b_neg = signed_op && b_i[WIDTH-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // Shift-add step: conditionally add into the upper half, then shift the whole pair right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, prod;
    assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mag_q} : '0);
    assign mul_next = {mul_sum, p_q[WIDTH-1:1]};
    assign prod     = neg_q ? -p_q : p_q;

`ifdef HILO_MULDIV_DIV_EN
    logic               neg_rem_q, neg_rem_d;  // remainder follows the dividend's sign
    logic               dz_q, dz_d;
    logic               is_div, rem_ge;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_next;
    assign is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    // Restoring step: bring in the next dividend bit, subtract if it fits, shift in the quotient bit.
    // rem_sh < 2*divisor, so WIDTH+1 bits suffice and the restored value fits in WIDTH.
    assign rem_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign rem_ge   = rem_sh >= {1'b0, mag_q};
    assign rem_new  = rem_ge ? WIDTH'(rem_sh - {1'b0, mag_q}) : rem_sh[WIDTH-1:0];
    assign div_next = {rem_new, p_q[WIDTH-2:0], rem_ge};
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        mag_d     = mag_q;
        p_d       = p_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divz_d    = 1'b0;
        illegal_d = 1'b0;
`ifdef HILO_MULDIV_DIV_EN
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
`endif
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        case (op_in)
                            OP_MTHI: begin hi_d = a_i; done_d = 1'b1; end
                            OP_MTLO: begin lo_d = a_i; done_d = 1'b1; end
`ifndef HILO_MULDIV_DIV_EN
                            OP_DIV, OP_DIVU: begin done_d = 1'b1; illegal_d = 1'b1; end
`endif
                            default: begin
                                op_d    = op_in;
                                neg_d   = a_neg ^ b_neg;
                                mag_d   = b_mag;
                                p_d     = {{WIDTH{1'b0}}, a_mag};
                                cnt_d   = CW'(WIDTH - 1);
                                state_d = S_RUN;
`ifdef HILO_MULDIV_DIV_EN
                                neg_rem_d = a_neg;
                                dz_d      = (b_i == '0);
`endif
                            end
                        endcase
                    end
                end
                S_RUN: begin
`ifdef HILO_MULDIV_DIV_EN
                    p_d = is_div ? div_next : mul_next;
`else
                    p_d = mul_next;
`endif
                    if (cnt_q == '0) state_d = S_FINISH;
                    else             cnt_d   = cnt_q - CW'(1);
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    case (op_q)
                        OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod;
                        OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod;
                        default: {hi_d, lo_d} = prod;
                    endcase
`ifdef HILO_MULDIV_DIV_EN
                    if (is_div) begin
                        hi_d   = neg_rem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
                        lo_d   = dz_q ? '1 : (neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0]);
                        divz_d = dz_q;
                    end
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q      <= OP_MULT;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            mag_q     <= '0;
            p_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divz_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef HILO_MULDIV_DIV_EN
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            mag_q     <= mag_d;
            p_q       <= p_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divz_q    <= divz_d;
            illegal_q <= illegal_d;
`ifdef HILO_MULDIV_DIV_EN
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
`endif
        end
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign div_zero_o = divz_q;
    assign illegal_o  = illegal_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed vectors, randomized ops against an arithmetic
// reference model of HI/LO, flush and mid-operation reset scenarios.
module tb_hilo_muldiv_unit;

    localparam int W    = 32;
    localparam int LONG = W + 1;

    logic         clk     = 1'b0;
    logic         rst_n_r = 1'b1;
    logic         start_r = 1'b0;
    logic [2:0]   op_r    = 3'd0;
    logic [W-1:0] a_r     = '0;
    logic [W-1:0] b_r     = '0;
    logic         flush_r = 1'b0;
    logic         busy, done, div_zero, illegal;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    // Reference architectural state.
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_n_i(rst_n_r), .start_i(start_r), .op_i(op_r),
        .a_i(a_r), .b_i(b_r), .flush_i(flush_r),
        .busy_o(busy), .done_o(done), .div_zero_o(div_zero), .illegal_o(illegal),
        .hi_o(hi), .lo_o(lo)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: HI/LO update from plain wide arithmetic, plus expected timing/flags.
    task automatic model_op(input logic [2:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                            output int e_lat, output int e_bcnt, output logic e_dz, output logic e_il);
        logic [63:0] acc, uprod;
        longint      la, lb, sprod, q, r;
        acc    = {m_hi, m_lo};
        la     = longint'($signed(ma));
        lb     = longint'($signed(mb));
        sprod  = la * lb;
        uprod  = {32'b0, ma} * {32'b0, mb};
        e_lat  = LONG;
        e_bcnt = LONG;
        e_dz   = 1'b0;
        e_il   = 1'b0;
        case (mop)
            3'd0: acc = sprod;
            3'd1: acc = uprod;
            3'd2: acc = acc + sprod;
            3'd3: acc = acc - sprod;
            3'd4, 3'd5: begin
`ifdef HILO_MULDIV_DIV_EN
                if (mb == '0) begin
                    acc  = {ma, 32'hFFFF_FFFF};
                    e_dz = 1'b1;
                end else if (mop == 3'd4) begin
                    q   = la / lb;
                    r   = la % lb;
                    acc = {r[31:0], q[31:0]};
                end else begin
                    acc = {ma % mb, ma / mb};
                end
`else
                e_lat  = 0;
                e_bcnt = 0;
                e_il   = 1'b1;
`endif
            end
            3'd6: begin acc[63:32] = ma; e_lat = 0; e_bcnt = 0; end
            default: begin acc[31:0] = ma; e_lat = 0; e_bcnt = 0; end
        endcase
        {m_hi, m_lo} = acc;
    endtask

    // Issue one op and collect what the DUT does; bounded wait for Done.
    task automatic launch(input logic [2:0] lop, input logic [W-1:0] la, input logic [W-1:0] lb,
                          output int lat, output int bcnt, output logic [W-1:0] ohi,
                          output logic [W-1:0] olo, output logic odz, output logic oil,
                          output logic pulse_ok);
        @(negedge clk);
        start_r = 1'b1; op_r = lop; a_r = la; b_r = lb;
        @(negedge clk);
        start_r = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) @(negedge clk);
            if (busy) bcnt++;
            if (done) begin lat = k; break; end
        end
        ohi = hi; olo = lo; odz = div_zero; oil = illegal;
        @(negedge clk);
        pulse_ok = !done && !div_zero && !illegal;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        #1 rst_n_r = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (hi !== '0) begin n_err++; $display("FAIL reset hi: got %h want 0", hi); end
        n_cmp++; if (lo !== '0) begin n_err++; $display("FAIL reset lo: got %h want 0", lo); end
        n_cmp++; if ({busy, done, div_zero, illegal} !== 4'b0)
            begin n_err++; $display("FAIL reset flags: got %b want 0000", {busy, done, div_zero, illegal}); end
        rst_n_r = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post-reset busy: got %b want 0", busy); end
    endtask

    task automatic test_mul_vectors();
        int lat, bcnt, el, eb; logic [W-1:0] ohi, olo; logic dz, il, pk, edz, eil;
        launch(3'd0, 32'hFFFF_FFFD, 32'd7, lat, bcnt, ohi, olo, dz, il, pk);
        model_op(3'd0, 32'hFFFF_FFFD, 32'd7, el, eb, edz, eil);
        n_cmp++; if ({ohi, olo} !== 64'hFFFF_FFFF_FFFF_FFEB)
            begin n_err++; $display("FAIL mult -3*7: got %h_%h want ffffffff_ffffffeb", ohi, olo); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mult latency: got %0d want 33", lat); end
        n_cmp++; if (bcnt !== 33) begin n_err++; $display("FAIL mult busy cycles: got %0d want 33", bcnt); end
        n_cmp++; if (pk !== 1'b1) begin n_err++; $display("FAIL mult done pulse width: got %b want 1", pk); end
        launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, ohi, olo, dz, il, pk);
        model_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, el, eb, edz, eil);
        n_cmp++; if ({ohi, olo} !== 64'hFFFF_FFFE_0000_0001)
            begin n_err++; $display("FAIL multu max: got %h_%h want fffffffe_00000001", ohi, olo); end
        launch(3'd6, 32'd5, 32'd0, lat, bcnt, ohi, olo, dz, il, pk);
        model_op(3'd6, 32'd5, 32'd0, el, eb, edz, eil);
        n_cmp++; if (ohi !== 32'd5 || lat !== 0 || bcnt !== 0)
            begin n_err++; $display("FAIL mthi: got hi=%h lat=%0d busy=%0d want 5/0/0", ohi, lat, bcnt); end
        launch(3'd7, 32'hFFFF_FFFF, 32'd0, lat, bcnt, ohi, olo, dz, il, pk);
        model_op(3'd7, 32'hFFFF_FFFF, 32'd0, el, eb, edz, eil);
        n_cmp++; if (olo !== 32'hFFFF_FFFF || lat !== 0)
            begin n_err++; $display("FAIL mtlo: got lo=%h lat=%0d want ffffffff/0", olo, lat); end
        launch(3'd2, 32'd2, 32'd3, lat, bcnt, ohi, olo, dz, il, pk);
        model_op(3'd2, 32'd2, 32'd3, el, eb, edz, eil);
        n_cmp++; if ({ohi, olo} !== 64'h0000_0006_0000_0005)
            begin n_err++; $display("FAIL madd carry: got %h_%h want 00000006_00000005", ohi, olo); end
        launch(3'd3, 32'd2, 32'd3, lat, bcnt, ohi, olo, dz, il, pk);
        model_op(3'd3, 32'd2, 32'd3, el, eb, edz, eil);
        n_cmp++; if ({ohi, olo} !== 64'h0000_0005_FFFF_FFFF)
            begin n_err++; $display("FAIL msub borrow: got %h_%h want 00000005_ffffffff", ohi, olo); end
    endtask

    task automatic test_div_vectors();
        logic [2:0]   tops [6] = '{3'd4, 3'd5, 3'd4, 3'd4, 3'd4, 3'd5};
        logic [W-1:0] ta   [6] = '{32'hFFFF_FFF9, 32'd9, 32'h8000_0000, 32'hFFFF_FFF7, 32'd7, 32'd100};
        logic [W-1:0] tb   [6] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 32'd7};
        int lat, bcnt, el, eb; logic [W-1:0] ohi, olo; logic dz, il, pk, edz, eil;
        for (int i = 0; i < 6; i++) begin
            launch(tops[i], ta[i], tb[i], lat, bcnt, ohi, olo, dz, il, pk);
            model_op(tops[i], ta[i], tb[i], el, eb, edz, eil);
            n_cmp++; if (ohi !== m_hi) begin n_err++; $display("FAIL div[%0d] hi: got %h want %h", i, ohi, m_hi); end
            n_cmp++; if (olo !== m_lo) begin n_err++; $display("FAIL div[%0d] lo: got %h want %h", i, olo, m_lo); end
            n_cmp++; if (lat !== el || bcnt !== eb)
                begin n_err++; $display("FAIL div[%0d] timing: got lat=%0d busy=%0d want %0d/%0d", i, lat, bcnt, el, eb); end
            n_cmp++; if ({dz, il, pk} !== {edz, eil, 1'b1})
                begin n_err++; $display("FAIL div[%0d] flags dz/il/pulse: got %b want %b", i, {dz, il, pk}, {edz, eil, 1'b1}); end
        end
    endtask

    task automatic test_flush();
        logic saw_done;
        int el, eb; logic edz, eil;
        // Flush mid-run, with a stray Start while busy.
        @(negedge clk); start_r = 1'b1; op_r = 3'd0; a_r = 32'd1234; b_r = 32'd5678;
        @(negedge clk); start_r = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3) begin start_r = 1'b1; op_r = 3'd7; a_r = 32'h0000_1234; end
            else start_r = 1'b0;
        end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush pre busy: got %b want 1", busy); end
        flush_r = 1'b1;
        @(negedge clk); flush_r = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush busy: got %b want 0", busy); end
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin @(negedge clk); if (done) saw_done = 1'b1; end
        n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL flush run done: got 1 want 0"); end
        n_cmp++; if ({hi, lo} !== {m_hi, m_lo})
            begin n_err++; $display("FAIL flush run hilo: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
        // Flush during FINISH suppresses the commit.
        @(negedge clk); start_r = 1'b1; op_r = 3'd0; a_r = 32'd99; b_r = 32'd77;
        @(negedge clk); start_r = 1'b0;
        repeat (32) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL finish busy: got %b want 1", busy); end
        flush_r = 1'b1;
        @(negedge clk); flush_r = 1'b0;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL finish flush busy/done: got %b want 00", {busy, done}); end
        n_cmp++; if ({hi, lo} !== {m_hi, m_lo})
            begin n_err++; $display("FAIL finish flush hilo: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
        // Flush with Start in IDLE: nothing launches.
        @(negedge clk); start_r = 1'b1; flush_r = 1'b1; op_r = 3'd6; a_r = 32'h1357_9BDF;
        @(negedge clk); start_r = 1'b0; flush_r = 1'b0;
        n_cmp++; if ({busy, done} !== 2'b00 || hi !== m_hi)
            begin n_err++; $display("FAIL flush+start: got busy/done=%b hi=%h want 00/%h", {busy, done}, hi, m_hi); end
        model_op(3'd7, lo, 32'd0, el, eb, edz, eil);
    endtask

    task automatic test_random();
        int lat, bcnt, el, eb; logic [W-1:0] ohi, olo, ra, rb; logic [2:0] ro; logic dz, il, pk, edz, eil;
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = rnd_operand();
            rb = rnd_operand();
            launch(ro, ra, rb, lat, bcnt, ohi, olo, dz, il, pk);
            model_op(ro, ra, rb, el, eb, edz, eil);
            n_cmp++; if ({ohi, olo} !== {m_hi, m_lo})
                begin n_err++; $display("FAIL rand[%0d] op%0d a=%h b=%h hilo: got %h_%h want %h_%h", i, ro, ra, rb, ohi, olo, m_hi, m_lo); end
            n_cmp++; if (lat !== el || bcnt !== eb)
                begin n_err++; $display("FAIL rand[%0d] op%0d timing: got lat=%0d busy=%0d want %0d/%0d", i, ro, lat, bcnt, el, eb); end
            n_cmp++; if ({dz, il, pk} !== {edz, eil, 1'b1})
                begin n_err++; $display("FAIL rand[%0d] op%0d flags dz/il/pulse: got %b want %b", i, ro, {dz, il, pk}, {edz, eil, 1'b1}); end
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, el, eb; logic [W-1:0] ohi, olo; logic dz, il, pk, edz, eil;
        launch(3'd6, 32'hA5A5_A5A5, 32'd0, lat, bcnt, ohi, olo, dz, il, pk);
        model_op(3'd6, 32'hA5A5_A5A5, 32'd0, el, eb, edz, eil);
        launch(3'd7, 32'h5A5A_5A5A, 32'd0, lat, bcnt, ohi, olo, dz, il, pk);
        model_op(3'd7, 32'h5A5A_5A5A, 32'd0, el, eb, edz, eil);
        @(negedge clk); start_r = 1'b1; op_r = 3'd3; a_r = 32'd3; b_r = 32'd4;
        @(negedge clk); start_r = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n_r = 1'b0;
        #1;
        n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL midreset hilo: got %h_%h want 0", hi, lo); end
        n_cmp++; if ({busy, done, div_zero, illegal} !== 4'b0)
            begin n_err++; $display("FAIL midreset flags: got %b want 0000", {busy, done, div_zero, illegal}); end
        m_hi = '0; m_lo = '0;
        @(negedge clk); rst_n_r = 1'b1;
        launch(3'd0, 32'd2, 32'd3, lat, bcnt, ohi, olo, dz, il, pk);
        model_op(3'd0, 32'd2, 32'd3, el, eb, edz, eil);
        n_cmp++; if ({ohi, olo} !== 64'd6 || lat !== 33)
            begin n_err++; $display("FAIL after-reset mult: got %h_%h lat=%0d want 0_6 lat=33", ohi, olo, lat); end
    endtask

    initial begin
        test_reset();
        test_mul_vectors();
        test_div_vectors();
        test_flush();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
